icdc_mem_arbiter: RTL

- Shares the single external 32-bit memory port between the I-cache tile-fill port (PC side) and the D-cache port (data side).
- Sits between the I-cache/D-cache tiles and the memory/bus interface.
- Holds the grant for the whole 4-DWORD I-tile burst.
- Alternates priority when both sides contend, and times out stalled transfers.

---
 rtl/icdc_mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/icdc_mem_arbiter.sv
// Arbiter that shares one 32-bit external memory port between the I-cache
// tile-fill side (PC) and the D-cache side (DC). A grant is held for a whole
// 4-beat I-tile burst, priority alternates under contention, and a beat that
// waits too long for memOK is aborted with a one-cycle arbErr pulse.
module icdc_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter bit          DPRIO   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pcAddr,
    input  logic        pcOE,
    output logic [31:0] pcData,
    output logic        pcOK,
    input  logic [31:0] dcAddr,
    input  logic [31:0] dcDataIn,
    input  logic        dcOE,
    input  logic        dcWR,
    output logic [31:0] dcData,
    output logic        dcOK,
    output logic [31:0] memAddr,
    output logic [31:0] memDataOut,
    output logic        memOE,
    output logic        memWR,
    input  logic [31:0] memDataIn,
    input  logic        memOK,
    output logic        arbErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_PC = 2'd1,
        GNT_DC = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;     // 1: data side wins a tie, 0: PC side wins
    logic [7:0] cnt_q, cnt_d;       // cycles spent waiting for memOK on this beat
    logic       dc_req;
    logic       timeout_hit;

    assign dc_req      = dcOE | dcWR;
    assign timeout_hit = (cnt_q == TIMEOUT_C);

    // State, priority and timeout counter registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            prio_q  <= DPRIO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, priority update, timeout counting and abort pulse
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        arbErr  = 1'b0;
        case (state_q)
            IDLE: begin
                // Counter is held at zero here so every grant starts fresh.
                cnt_d = '0;
                if (pcOE && (!dc_req || !prio_q)) begin
                    state_d = GNT_PC;
                end else if (dc_req) begin
                    state_d = GNT_DC;
                end
            end
            GNT_PC: begin
                if (memOK) begin
                    // memOK beats a simultaneous timeout: the beat completes.
                    cnt_d = '0;
                    if (pcAddr[3:2] == 2'b11) begin
                        state_d = IDLE;
                        prio_d  = 1'b1;
                    end
                end else if (!pcOE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    arbErr  = 1'b1;
                    prio_d  = ~prio_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GNT_DC: begin
                if (memOK) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    prio_d  = 1'b0;
                end else if (!dc_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    arbErr  = 1'b1;
                    prio_d  = ~prio_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus drive and OK/data return routing, gated by the registered grant
    always_comb begin
        memAddr    = '0;
        memDataOut = '0;
        memOE      = 1'b0;
        memWR      = 1'b0;
        pcOK       = 1'b0;
        dcOK       = 1'b0;
        pcData     = '0;
        dcData     = '0;
        case (state_q)
            GNT_PC: begin
                memAddr = pcAddr;
                memOE   = pcOE;
                pcOK    = memOK;
                pcData  = memOK ? memDataIn : 32'd0;
            end
            GNT_DC: begin
                memAddr    = dcAddr;
                memDataOut = dcDataIn;
                memWR      = dcWR;
                // A write request takes precedence over a read on the same beat.
                memOE      = dcOE & ~dcWR;
                dcOK       = memOK;
                dcData     = memOK ? memDataIn : 32'd0;
            end
            default: ;
        endcase
    end

endmodule
